// File: rtl/adpll_pkg.sv
// adpll_pkg: shared widths, gains, types and lock states for the ADPLL loop filter
package adpll_pkg;
  localparam int PD_WIDTH   = 20;
  localparam int CTRL_WIDTH = 24;
  localparam int INT_WIDTH  = 26;
  localparam int SUM_WIDTH  = INT_WIDTH + 2;
  localparam int KP_SHIFT   = 2;
  localparam int KI_SHIFT   = 6;
  localparam int INT_LIMIT  = 2**20;
  localparam int LOCK_TOL   = 4;
  localparam int LOCK_COUNT = 16;
  localparam logic [CTRL_WIDTH-1:0] CTRL_CENTER = 24'h100000;
  typedef logic signed [PD_WIDTH-1:0]  pd_err_t;
  typedef logic        [CTRL_WIDTH-1:0] ctrl_word_t;
  typedef logic signed [INT_WIDTH-1:0] integ_t;
  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} lock_state_e;
endpackage

// File: rtl/sat_add.sv
// sat_add: signed add of two IW-bit operands, clamped to [MIN, MAX] and cut to OW bits
module sat_add #(
  parameter int IW = 26,
  parameter int OW = 26,
  parameter logic signed [IW:0] MIN = '0,
  parameter logic signed [IW:0] MAX = '0
) (
  input  logic [IW-1:0] i_a,
  input  logic [IW-1:0] i_b,
  output logic [OW-1:0] o_y
);
  logic signed [IW:0] w_sum;
  assign w_sum = $signed({i_a[IW-1], i_a}) + $signed({i_b[IW-1], i_b});
  assign o_y = (w_sum > MAX) ? MAX[OW-1:0] : (w_sum < MIN) ? MIN[OW-1:0] : w_sum[OW-1:0];
endmodule

// File: rtl/loop_filter.sv
// loop_filter: two-stage PI loop filter producing a saturated DCO control word and lock flag
module loop_filter
  import adpll_pkg::*;
(
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic [PD_WIDTH-1:0]   pd_err_i,
  input  logic                  pd_valid_i,
  input  logic                  hold_i,
  input  logic                  clear_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic                  ctrl_valid_o,
  output logic                  locked_o
);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [SUM_WIDTH-1:0] CENTER_X = SUM_WIDTH'(CTRL_CENTER);

  logic        w_accept;
  integ_t      w_err_x;
  integ_t      w_integ_nx;
  integ_t      r_integ;
  integ_t      r_p;
  logic        r_v1;
  ctrl_word_t  w_ctrl;
  logic [PD_WIDTH-1:0]  w_abs;
  logic        w_in_tol;
  lock_state_e r_state;
  lock_state_e w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] w_cnt_inc;
  logic        w_locked;
  logic [SUM_WIDTH-1:0] w_sum_a;
  logic [SUM_WIDTH-1:0] w_sum_b;

  assign w_accept  = pd_valid_i & ~clear_i;
  assign w_err_x   = {{(INT_WIDTH-PD_WIDTH){pd_err_i[PD_WIDTH-1]}}, pd_err_i};
  // Saturating magnitude: the most negative code negates to itself and stays far outside tolerance.
  assign w_abs     = pd_err_i[PD_WIDTH-1] ? -pd_err_i : pd_err_i;
  assign w_in_tol  = (pd_err_i != {1'b1, {(PD_WIDTH-1){1'b0}}}) && (w_abs <= PD_WIDTH'(LOCK_TOL));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_sum_a   = CENTER_X + {{(SUM_WIDTH-INT_WIDTH){r_p[INT_WIDTH-1]}}, r_p};
  assign w_sum_b   = {{(SUM_WIDTH-INT_WIDTH){r_integ[INT_WIDTH-1]}}, r_integ};

  sat_add #(
    .IW(INT_WIDTH), .OW(INT_WIDTH),
    .MIN((INT_WIDTH+1)'(-INT_LIMIT)), .MAX((INT_WIDTH+1)'(INT_LIMIT))
  ) u_integ_sat (
    .i_a(r_integ), .i_b(w_err_x >>> KI_SHIFT), .o_y(w_integ_nx)
  );

  sat_add #(
    .IW(SUM_WIDTH), .OW(CTRL_WIDTH),
    .MIN('0), .MAX((SUM_WIDTH+1)'(2**CTRL_WIDTH - 1))
  ) u_ctrl_sat (
    .i_a(w_sum_a), .i_b(w_sum_b), .o_y(w_ctrl)
  );

  // Stage 1: capture proportional term and advance the clamped integrator
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v1    <= 1'b0;
      r_p     <= '0;
      r_integ <= '0;
    end else begin
      r_v1 <= w_accept;
      if (clear_i) r_integ <= '0;
      else if (pd_valid_i) begin
        r_p <= w_err_x >>> KP_SHIFT;
        if (!hold_i) r_integ <= w_integ_nx;
      end
    end
  end

  // Stage 2: publish the clamped control word with its lock status
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_o       <= CTRL_CENTER;
      ctrl_valid_o <= 1'b0;
      locked_o     <= 1'b0;
    end else begin
      ctrl_valid_o <= r_v1;
      if (r_v1) ctrl_o <= w_ctrl;
      locked_o <= clear_i ? 1'b0 : r_v1 ? w_locked : locked_o;
    end
  end

  // Lock FSM state register
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= UNLOCKED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Lock FSM next state: evaluated once per accepted sample, clear wins
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (clear_i || (pd_valid_i && !w_in_tol)) begin
      w_state_nx = UNLOCKED;
      w_cnt_nx   = '0;
    end else if (pd_valid_i && r_state == UNLOCKED) begin
      w_state_nx = LOCKING;
      w_cnt_nx   = CW'(1);
    end else if (pd_valid_i && r_state == LOCKING) begin
      w_cnt_nx   = w_cnt_inc;
      w_state_nx = (w_cnt_inc == CW'(LOCK_COUNT)) ? LOCKED : LOCKING;
    end
  end

  // Lock FSM output decode
  always_comb begin
    w_locked = (r_state == LOCKED);
  end
endmodule

// File: tb/tb_loop_filter.sv
// tb_loop_filter: directed checks of latency, PI arithmetic, saturation, hold, clear and lock
module tb_loop_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] pd_err = '0;
  logic        pd_valid = 1'b0;
  logic        hold = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] ctrl;
  logic        ctrl_valid;
  logic        locked;
  int n_chk = 0;
  int n_pass = 0;
  int prev;
  int bad;

  loop_filter dut (
    .fpga_clk_i(clk), .reset_n_i(rst_n), .pd_err_i(pd_err), .pd_valid_i(pd_valid),
    .hold_i(hold), .clear_i(clear), .ctrl_o(ctrl), .ctrl_valid_o(ctrl_valid), .locked_o(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int e);
    pd_err = 20'(e);
    pd_valid = 1'b1;
    tick();
    pd_valid = 1'b0;
  endtask

  task automatic sample(input int e);
    pulse(e);
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    pd_err = 20'd1000;
    pd_valid = 1'b1;
    repeat (3) tick();
    chk("rst_ctrl", ctrl, 1048576);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_locked", locked, 0);
    pd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    pulse(100);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst_flight_valid", ctrl_valid, 0);
    chk("rst_flight_ctrl", ctrl, 1048576);
    pulse(10);
    chk("lat_n1_valid", ctrl_valid, 0);
    tick();
    chk("lat_n2_valid", ctrl_valid, 1);
    chk("p10_ctrl", ctrl, 1048578);
    tick();
    chk("lat_n3_valid", ctrl_valid, 0);
    chk("ctrl_hold", ctrl, 1048578);
    for (int i = 0; i < 4; i++) begin
      sample(64);
      chk("pos64_ctrl", ctrl, 1048593 + i);
      repeat (38) tick();
    end
    do_clear();
    sample(-64);
    chk("neg64_ctrl_a", ctrl, 1048559);
    sample(-64);
    chk("neg64_ctrl_b", ctrl, 1048558);
    sample(-1);
    chk("neg1_ctrl", ctrl, 1048572);
    sample(0);
    chk("neg1_floor", ctrl, 1048573);
    do_clear();
    pd_err = 20'd128;
    pd_valid = 1'b1;
    tick();
    tick();
    pd_valid = 1'b0;
    chk("b2b_valid_a", ctrl_valid, 1);
    chk("b2b_ctrl_a", ctrl, 1048610);
    tick();
    chk("b2b_valid_b", ctrl_valid, 1);
    chk("b2b_ctrl_b", ctrl, 1048612);
    tick();
    chk("b2b_valid_end", ctrl_valid, 0);
    hold = 1'b1;
    sample(256);
    hold = 1'b0;
    chk("hold_ctrl", ctrl, 1048644);
    sample(0);
    chk("hold_integ", ctrl, 1048580);
    clear = 1'b1;
    pd_err = '0;
    pd_valid = 1'b1;
    tick();
    clear = 1'b0;
    pd_valid = 1'b0;
    tick();
    chk("clr_no_valid", ctrl_valid, 0);
    sample(0);
    chk("clr_integ0", ctrl, 1048576);
    do_clear();
    for (int i = 0; i < 16; i++) begin
      sample(3);
      if (i == 14) chk("lock_15th", locked, 0);
    end
    chk("lock_16th", locked, 1);
    chk("lock_16th_valid", ctrl_valid, 1);
    sample(5);
    chk("unlock_err5", locked, 0);
    chk("unlock_ctrl", ctrl, 1048577);
    for (int i = 0; i < 16; i++) sample(-4);
    chk("lock_neg4", locked, 1);
    chk("lock_neg4_ctrl", ctrl, 1048559);
    sample(-524288);
    chk("unlock_most_neg", locked, 0);
    chk("most_neg_ctrl", ctrl, 909296);
    do_clear();
    prev = 0;
    bad = 0;
    pd_err = 20'd524287;
    pd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (ctrl_valid && int'(ctrl) < prev) bad++;
      prev = int'(ctrl);
    end
    pd_valid = 1'b0;
    tick();
    tick();
    chk("sat_pos_no_wrap", bad, 0);
    chk("sat_pos_ctrl", ctrl, 2228223);
    sample(0);
    chk("sat_pos_integ", ctrl, 2097152);
    do_clear();
    pd_err = 20'h80000;
    pd_valid = 1'b1;
    repeat (2000) tick();
    pd_valid = 1'b0;
    tick();
    tick();
    chk("sat_neg_ctrl", ctrl, 0);
    sample(0);
    chk("sat_neg_integ", ctrl, 0);
    sample(524287);
    chk("sat_neg_recover", ctrl, 139262);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
